// File: rtl/display_scan_ctrl_if.sv
// Bundle between the value-producing datapath (master) and the display scan
// controller (slave): hex value, control strobes and the registered pin drives.
interface display_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                enable;
  logic                blank_lz;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, dp_in, load, enable, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value, dp_in, load, enable, blank_lz,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with tear-free
// shadow updates, leading-zero blanking and a blank guard at each slot start.
module display_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 16
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] pending;
  logic [DIGITS-1:0]   pending_dp;
  logic                pending_valid;
  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   shadow_dp;

  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic                frame_done_q;

  logic                frame_end;
  logic                apply_now;
  logic                upper_zero;
  logic [DIGITS-1:0]   lz_mask;
  logic [3:0]          cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign frame_end = bus.enable && (cnt == CNT_LAST) && (idx == IDX_LAST);
  // Shadow may only change between frames, or at any time while the scan is idle.
  assign apply_now = !bus.enable || frame_end;
  assign cur_digit = shadow[{idx, 2'b00} +: 4];

  // NOTE: upper_zero is a running AND down the digit chain, so it must use
  // blocking assignments, and it gets a default first so no latch is inferred.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (shadow[4*i +: 4] == 4'h0);
      lz_mask[i] = bus.blank_lz && (i != 0) && upper_zero;
    end
  end

  // NOTE: the shadow/pending registers are plain flops here, so they are reset
  // with everything else; state registers take non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      idx           <= '0;
      pending       <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      shadow        <= '0;
      shadow_dp     <= '0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      if (bus.load) begin
        if (apply_now) begin
          shadow        <= bus.value;
          shadow_dp     <= bus.dp_in;
          pending_valid <= 1'b0;
        end else begin
          pending       <= bus.value;
          pending_dp    <= bus.dp_in;
          pending_valid <= 1'b1;
        end
      end else if (pending_valid && apply_now) begin
        shadow        <= pending;
        shadow_dp     <= pending_dp;
        pending_valid <= 1'b0;
      end

      if (!bus.enable) begin
        cnt <= '0;
        idx <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      frame_done_q <= frame_end;

      // The guard window blanks every anode to stop the previous digit ghosting.
      if (!bus.enable || (cnt < CNT_GUARD)) begin
        an_q  <= '1;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= ~(DIGITS'(1) << idx);
        seg_q <= lz_mask[idx] ? 7'h7F : decode(cur_digit);
        dp_q  <= ~shadow_dp[idx];
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: spec vectors, multi-cycle corner
// sequences and randomized traffic against a cycle-count based reference model.
module tb_display_scan_ctrl;

  localparam int D = 4;
  localparam int P = 8;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  display_scan_ctrl_if #(.DIGITS(D)) bus ();

  display_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .GUARD(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: m_t counts cycles since the scan (re)started.
  int          m_t;
  logic [15:0] m_shadow, m_pend;
  logic [3:0]  m_sdp, m_pdp;
  logic        m_pvalid;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blz;
    int          digit;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_t      = 0;
    m_shadow = '0;
    m_pend   = '0;
    m_sdp    = '0;
    m_pdp    = '0;
    m_pvalid = 1'b0;
  endtask

  // One clock: predict the registered outputs, advance the model, compare.
  task automatic tick();
    int          slot_pos, digit;
    logic        bnd;
    logic [15:0] upper;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_dp, e_fd;
    slot_pos = m_t % P;
    digit    = (m_t / P) % D;
    bnd      = bus.enable && (m_t == P * D - 1);
    if (!bus.enable || slot_pos < G) begin
      e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      upper = m_shadow >> (4 * digit);
      e_an  = ~(4'b0001 << digit);
      e_seg = (bus.blank_lz && digit > 0 && upper == 16'h0) ? 7'h7F : dec[upper[3:0]];
      e_dp  = ~m_sdp[digit];
    end
    e_fd = bnd;
    if (bus.load) begin
      if (!bus.enable || bnd) begin
        m_shadow = bus.value; m_sdp = bus.dp_in; m_pvalid = 1'b0;
      end else begin
        m_pend = bus.value; m_pdp = bus.dp_in; m_pvalid = 1'b1;
      end
    end else if (m_pvalid && (!bus.enable || bnd)) begin
      m_shadow = m_pend; m_sdp = m_pdp; m_pvalid = 1'b0;
    end
    m_t = bus.enable ? (m_t + 1) % (P * D) : 0;
    @(posedge clk);
    #1;
    check("scan", {19'b0, bus.an, bus.seg, bus.dp, bus.frame_done},
                  {19'b0, e_an, e_seg, e_dp, e_fd});
  endtask

  // Tick until the model has just processed scan position 'target'.
  task automatic advance_to(input int target);
    int n = 0;
    while (m_t != target && n < P * D + 2) begin
      tick();
      n++;
    end
    if (m_t != target) check("advance bound", 32'(m_t), 32'(target));
    tick();
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] dpv);
    bus.value = v;
    bus.dp_in = dpv;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  // Stop the scan, write the shadow directly, restart from digit 0.
  task automatic show(input logic [15:0] v, input logic [3:0] dpv, input logic blz);
    bus.enable   = 1'b0;
    bus.blank_lz = blz;
    tick();
    load_pulse(v, dpv);
    bus.enable = 1'b1;
  endtask

  initial begin
    int nfd, first, second;

    vecs[0]  = '{16'h12AF, 4'b0000, 1'b0, 0, 4'b1110, 7'b0001110, 1'b1};
    vecs[1]  = '{16'h12AF, 4'b0000, 1'b0, 1, 4'b1101, 7'b0001000, 1'b1};
    vecs[2]  = '{16'h12AF, 4'b0000, 1'b0, 2, 4'b1011, 7'b0100100, 1'b1};
    vecs[3]  = '{16'h12AF, 4'b0000, 1'b0, 3, 4'b0111, 7'b1111001, 1'b1};
    vecs[4]  = '{16'h0040, 4'b0000, 1'b1, 3, 4'b0111, 7'h7F,      1'b1};
    vecs[5]  = '{16'h0040, 4'b0000, 1'b1, 2, 4'b1011, 7'h7F,      1'b1};
    vecs[6]  = '{16'h0040, 4'b0000, 1'b1, 1, 4'b1101, 7'b0011001, 1'b1};
    vecs[7]  = '{16'h0040, 4'b0000, 1'b1, 0, 4'b1110, 7'b1000000, 1'b1};
    vecs[8]  = '{16'h0040, 4'b0000, 1'b0, 3, 4'b0111, 7'b1000000, 1'b1};
    vecs[9]  = '{16'h0040, 4'b0000, 1'b0, 2, 4'b1011, 7'b1000000, 1'b1};
    vecs[10] = '{16'h0000, 4'b0000, 1'b1, 0, 4'b1110, 7'b1000000, 1'b1};
    vecs[11] = '{16'h0000, 4'b0000, 1'b1, 1, 4'b1101, 7'h7F,      1'b1};
    vecs[12] = '{16'h12AF, 4'b0100, 1'b0, 2, 4'b1011, 7'b0100100, 1'b0};
    vecs[13] = '{16'h12AF, 4'b0100, 1'b0, 1, 4'b1101, 7'b0001000, 1'b1};

    bus.value = '0; bus.dp_in = '0; bus.load = 1'b0;
    bus.enable = 1'b0; bus.blank_lz = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset an", 32'(bus.an), 32'hF);
    check("reset seg", 32'(bus.seg), 32'h7F);
    check("reset dp", 32'(bus.dp), 32'h1);
    check("reset frame_done", 32'(bus.frame_done), 32'h0);
    rst = 1'b0;
    model_reset();

    foreach (vecs[k]) begin
      show(vecs[k].value, vecs[k].dp_in, vecs[k].blz);
      repeat (vecs[k].digit * P + G + 1) tick();
      check("vec an", 32'(bus.an), 32'(vecs[k].an));
      check("vec seg", 32'(bus.seg), 32'(vecs[k].seg));
      check("vec dp", 32'(bus.dp), 32'(vecs[k].dp));
    end

    // frame_done cadence
    show(16'h12AF, 4'b0000, 1'b0);
    nfd = 0; first = -1; second = -1;
    for (int c = 1; c <= 3 * P * D; c++) begin
      tick();
      if (bus.frame_done) begin
        nfd++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    check("fd count", 32'(nfd), 32'd3);
    check("fd first", 32'(first), 32'd32);
    check("fd spacing", 32'(second - first), 32'd32);

    // Mid-frame load is held back until the next frame
    show(16'h12AF, 4'b0000, 1'b0);
    advance_to(P + 3);
    load_pulse(16'h8888, 4'b0000);
    advance_to(2 * P + G);
    check("midload idx2 old", 32'(bus.seg), 32'(7'b0100100));
    advance_to(3 * P + G);
    check("midload idx3 old", 32'(bus.seg), 32'(7'b1111001));
    advance_to(G);
    check("midload new an", 32'(bus.an), 32'hE);
    check("midload new seg", 32'(bus.seg), 32'(7'b0000000));

    // Load coincident with the frame boundary
    advance_to(P * D - 2);
    bus.value = 16'h3456; bus.dp_in = 4'b0000; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    advance_to(G);
    check("bndload idx0", 32'(bus.seg), 32'(7'b0000010));
    advance_to(P + G);
    check("bndload idx1", 32'(bus.seg), 32'(7'b0010010));

    // Enable drop mid-slot of digit 2, then re-assert
    advance_to(2 * P + 3);
    bus.enable = 1'b0;
    tick();
    check("disable an", 32'(bus.an), 32'hF);
    check("disable seg", 32'(bus.seg), 32'h7F);
    nfd = 0;
    repeat (40) begin
      tick();
      if (bus.frame_done) nfd++;
    end
    check("fd while disabled", 32'(nfd), 32'd0);
    bus.enable = 1'b1;
    repeat (G) begin
      tick();
      check("reenable guard an", 32'(bus.an), 32'hF);
    end
    tick();
    check("reenable an", 32'(bus.an), 32'hE);
    check("reenable seg", 32'(bus.seg), 32'(7'b0000010));

    // Async reset while a digit is lit
    advance_to(P + G + 1);
    rst = 1'b1;
    #1;
    check("async rst an", 32'(bus.an), 32'hF);
    check("async rst seg", 32'(bus.seg), 32'h7F);
    check("async rst dp", 32'(bus.dp), 32'h1);
    check("async rst fd", 32'(bus.frame_done), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (G + 1) tick();
    check("post rst an", 32'(bus.an), 32'hE);
    check("post rst seg", 32'(bus.seg), 32'(7'b1000000));

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      bus.value = 16'($urandom) & mask;
      bus.dp_in = 4'($urandom);
      bus.load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
      if (bus.enable) begin
        if ($urandom_range(0, 99) == 0) bus.enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.enable = 1'b1;
      end
      tick();
    end
    bus.load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode, multi-digit 7-segment display.
- Holds a shadow copy of a hex value, cycles through the digits with a prescaled refresh tick, and drives per-digit active-low anodes.
- Drives active-low segment and decimal-point outputs from an internal hex decode.
- Sits between the datapath that produces the value and the board display pins; provides tear-free updates, leading-zero blanking and anti-ghosting guard time.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- PRESCALE, 50000, clock cycles per digit slot (>= 2).
- GUARD, 16, blank cycles at the start of each slot (0 <= GUARD < PRESCALE).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- value  input  4*DIGITS  hex digits; digit i = value[4i+3:4i]; digit 0 is least significant.
- dp_in  input  DIGITS  per-digit decimal point request, active-high.
- load  input  1  single-cycle strobe; captures value/dp_in.
- enable  input  1  scan enable.
- blank_lz  input  1  leading-zero blanking enable.
- seg  output  7  segments, active-low, bit0 = a ... bit6 = g.
- dp  output  1  decimal point, active-low.
- an  output  DIGITS  anodes, active-low, one-hot-low when lit.
- frame_done  output  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset (async, any time including mid-slot):
  - seg=7'h7F, dp=1, an=all 1s, frame_done=0.
  - pending and shadow registers = 0.
  - slot counter cnt=0, digit index idx=0, pending_valid=0.
- Counters:
  - cnt runs 0..PRESCALE-1 while enable=1.
  - At cnt==PRESCALE-1: cnt->0 and idx->(idx+1) mod DIGITS.
  - Frame boundary = cnt==PRESCALE-1 && idx==DIGITS-1.
- Outputs are registered with 1-cycle latency: values present after edge t reflect (cnt, idx) as held during cycle t.
  - cnt < GUARD: an=all 1s, seg=7'h7F, dp=1.
  - Otherwise: an[idx]=0 and all other anode bits 1; seg=decode(shadow digit idx), unless blanked; dp=~shadow_dp[idx].
- Decode (seg, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
- Leading-zero blanking (blank_lz=1):
  - Digit i>0 shows seg=7'h7F when digit i and all digits above it are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- Load / shadow update (tear-free):
  - load=1 captures value/dp_in into the pending register and sets pending_valid.
  - A pending value transfers to shadow at the frame boundary edge; pending_valid then clears.
  - load in the same cycle as the boundary writes shadow directly, so the new value shows from idx 0.
  - A second load before the boundary overwrites pending; last load wins.
  - With enable=0, load writes shadow directly.
- Enable:
  - enable=0 → next edge: an=all 1s, seg=7'h7F, dp=1; cnt=0, idx=0, frame_done=0.
  - Re-assertion begins a new frame at idx 0 with a guard period; a pending value is applied at that point.
- frame_done is a registered pulse, high for exactly one cycle after each frame-boundary edge; it is never asserted while enable=0.
- No X on any output after reset; GUARD=0 means no blank interval.

Test Plan:
All cases use DIGITS=4, PRESCALE=8, GUARD=2.
- Basic scan:
  - Stimulus: load value=16'h12AF, enable=1.
  - Response, per 8-cycle slot: 2 blank cycles (an=1111, seg=7F), then 6 lit cycles in this order: an=1110 seg=0001110 (F); an=1101 seg=0001000 (A); an=1011 seg=0100100 (2); an=0111 seg=1111001 (1).
  - Response: frame_done pulses every 32 cycles.
- Leading zeros:
  - Stimulus: value=16'h0040, blank_lz=1.
  - Response: digits 3 and 2 show seg=7F; digit 1 shows 0011001; digit 0 shows 1000000.
  - Response with blank_lz=0: digits 3 and 2 show 1000000.
  - Response for value=0 with blank_lz=1: only digit 0 lit, showing 1000000.
- Mid-frame load:
  - Stimulus: load 16'h8888 while idx=1.
  - Response: idx 2 and 3 still show the old value; idx 0 of the next frame shows 0000000.
  - Stimulus: load coincident with the frame boundary.
  - Response: the new value appears at the immediately following idx 0.
- Decimal point:
  - Stimulus: dp_in=4'b0100 loaded.
  - Response: dp=0 only in the lit cycles of digit 2; dp=1 during guard cycles and all other slots.
- Enable drop:
  - Stimulus: deassert enable mid-slot of idx 2.
  - Response: next edge an=1111, seg=7F, counters 0.
  - Stimulus: re-assert enable.
  - Response: 2 guard cycles, then digit 0 lit; no frame_done during the disabled period.
- Async reset mid-lit-cycle:
  - Stimulus: assert rst while a digit is lit.
  - Response: an=1111, seg=7F, dp=1 immediately, before any clock edge.
  - Stimulus: release rst with enable=1.
  - Response: shadow=0, so digit 0 shows 1000000 after the guard cycles.
